// File: rtl/board_input_debouncer.sv
// Pushbutton/switch conditioner for the Nios PIO exports: per-bit 2-flop sync plus counter debounce.
// Define BUTTON_EDGE_CAPTURE_EN to build the press pulse and sticky press flag logic.
module board_input_debouncer #(
    parameter int N_BUTTONS       = 4,
    parameter int N_SWITCHES      = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [N_BUTTONS-1:0]  key_n_in,
    input  logic [N_SWITCHES-1:0] sw_in,
    output logic [N_BUTTONS-1:0]  button_export,
    output logic [N_SWITCHES-1:0] switch_export,
    output logic [N_BUTTONS-1:0]  press_pulse,
    output logic [N_BUTTONS-1:0]  press_flags,
    input  logic [N_BUTTONS-1:0]  flags_clear
);

    localparam int N_BITS = N_BUTTONS + N_SWITCHES;
    // Buttons idle high (released), switches idle low; bit order is {switches, buttons}.
    localparam logic [N_BITS-1:0] RST_VAL  = {{N_SWITCHES{1'b0}}, {N_BUTTONS{1'b1}}};
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BITS-1:0] w_raw;
    logic [N_BITS-1:0] r_sync1;
    logic [N_BITS-1:0] r_sync2;
    logic [N_BITS-1:0] r_stable;
    logic [N_BITS-1:0] w_stable_nxt;
    logic [CNT_W-1:0]  r_cnt     [N_BITS];
    logic [CNT_W-1:0]  w_cnt_nxt [N_BITS];

    assign w_raw = {sw_in, key_n_in};

    always_comb begin
        w_stable_nxt = r_stable;
        for (int i = 0; i < N_BITS; i++) begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            if (r_sync2[i] == r_stable[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == CNT_LAST) begin
                w_stable_nxt[i] = r_sync2[i];
                w_cnt_nxt[i]    = '0;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sync1  <= RST_VAL;
            r_sync2  <= RST_VAL;
            r_stable <= RST_VAL;
            for (int i = 0; i < N_BITS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1  <= w_raw;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_nxt;
            for (int i = 0; i < N_BITS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign button_export = r_stable[N_BUTTONS-1:0];
    assign switch_export = r_stable[N_BITS-1:N_BUTTONS];

`ifdef BUTTON_EDGE_CAPTURE_EN
    logic [N_BUTTONS-1:0] w_fall;
    logic [N_BUTTONS-1:0] r_pulse;
    logic [N_BUTTONS-1:0] r_flags;

    // Registered off the next-stable value so the pulse lines up with the export falling.
    assign w_fall = r_stable[N_BUTTONS-1:0] & ~w_stable_nxt[N_BUTTONS-1:0];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_pulse <= '0;
            r_flags <= '0;
        end else begin
            r_pulse <= w_fall;
            r_flags <= w_fall | (r_flags & ~flags_clear);
        end
    end

    assign press_pulse = r_pulse;
    assign press_flags = r_flags;
`else
    logic w_unused_clear;
    assign w_unused_clear = ^flags_clear;
    assign press_pulse    = '0;
    assign press_flags    = '0;
`endif

endmodule

// File: tb/tb_board_input_debouncer.sv
// Bench for board_input_debouncer: sampled-history window model, per-cycle scoreboard, directed and random stimulus.
module tb_board_input_debouncer;

    localparam int NB = 4;
    localparam int NS = 10;
    localparam int D  = 4;
    localparam int NT = NB + NS;
    localparam int EW = NT + 2 * NB;
`ifdef BUTTON_EDGE_CAPTURE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif
    localparam logic [NT-1:0] RST_VAL = {{NS{1'b0}}, {NB{1'b1}}};

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] key_n_in;
    logic [NS-1:0] sw_in;
    logic [NB-1:0] flags_clear;
    logic [NB-1:0] button_export;
    logic [NS-1:0] switch_export;
    logic [NB-1:0] press_pulse;
    logic [NB-1:0] press_flags;

    int vectors     = 0;
    int miscompares = 0;

    board_input_debouncer #(
        .N_BUTTONS      (NB),
        .N_SWITCHES     (NS),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .key_n_in      (key_n_in),
        .sw_in         (sw_in),
        .button_export (button_export),
        .switch_export (switch_export),
        .press_pulse   (press_pulse),
        .press_flags   (press_flags),
        .flags_clear   (flags_clear)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    // An input is accepted once the last D synchronized samples all disagree with
    // the accepted level; the synchronizer is a two-sample delay of the pin history.
    logic [NT-1:0] hist_q[$];
    logic [EW-1:0] exp_q[$];
    logic [NT-1:0] m_stable = RST_VAL;
    logic [NT-1:0] m_nxt;
    logic [NT-1:0] m_s;
    logic [NB-1:0] m_pulse = '0;
    logic [NB-1:0] m_flags = '0;
    logic [NB-1:0] m_fall;
    int            m_run;

    function automatic logic [NT-1:0] sync_seen(input int j);
        int idx;
        idx = hist_q.size() - 3 - j;
        return (idx >= 0) ? hist_q[idx] : RST_VAL;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q.delete();
            exp_q.delete();
            m_stable = RST_VAL;
            m_pulse  = '0;
            m_flags  = '0;
        end else begin
            hist_q.push_back({sw_in, key_n_in});
            if (hist_q.size() > D + 2) void'(hist_q.pop_front());
            m_nxt = m_stable;
            for (int b = 0; b < NT; b++) begin
                m_run = 0;
                for (int j = 0; j < D; j++) begin
                    m_s = sync_seen(j);
                    if (m_s[b] != m_stable[b]) m_run++;
                end
                if (m_run == D) m_nxt[b] = ~m_stable[b];
            end
            m_fall   = m_stable[NB-1:0] & ~m_nxt[NB-1:0];
            m_pulse  = EDGE_EN ? m_fall : '0;
            m_flags  = EDGE_EN ? (m_fall | (m_flags & ~flags_clear)) : '0;
            m_stable = m_nxt;
            exp_q.push_back({m_flags, m_pulse, m_stable});
        end
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] sb_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("sb_rst_button", button_export, RST_VAL[NB-1:0]);
            chk("sb_rst_switch", switch_export, '0);
            chk("sb_rst_pulse",  press_pulse,   '0);
            chk("sb_rst_flags",  press_flags,   '0);
        end else if (exp_q.size() != 0) begin
            sb_e = exp_q.pop_front();
            chk("sb_button", button_export, sb_e[NB-1:0]);
            chk("sb_switch", switch_export, sb_e[NT-1:NB]);
            chk("sb_pulse",  press_pulse,   sb_e[NT+NB-1:NT]);
            chk("sb_flags",  press_flags,   sb_e[EW-1:NT+NB]);
        end
    end

    // ---------------- directed + random stimulus ----------------
    int n_pulse;
    int hold;

    initial begin
        rst_n       = 1'b1;
        key_n_in    = 4'hF;
        sw_in       = 10'h3FF;
        flags_clear = '0;
        #2 rst_n = 1'b0;
        wait_n(3);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_button_now", button_export, 4'hF);
        chk("rst_switch_now", switch_export, 10'h000);
        chk("rst_flags_now",  press_flags,   4'h0);
        wait_n(5);
        chk("rst_switch_5", switch_export, 10'h000);
        wait_n(1);
        chk("rst_switch_6", switch_export, 10'h3FF);
        chk("rst_flags_6",  press_flags,   4'h0);

        // clean press on button 2
        key_n_in[2] = 1'b0;
        wait_n(5);
        chk("press_btn_5",   button_export, 4'hF);
        chk("press_pulse_5", press_pulse,   4'h0);
        wait_n(1);
        chk("press_btn_6",   button_export, 4'hB);
        chk("press_pulse_6", press_pulse,   EDGE_EN ? 4'h4 : 4'h0);
        chk("press_flags_6", press_flags,   EDGE_EN ? 4'h4 : 4'h0);
        wait_n(1);
        chk("press_pulse_7", press_pulse,   4'h0);
        chk("press_flags_7", press_flags,   EDGE_EN ? 4'h4 : 4'h0);
        key_n_in[2] = 1'b1;
        wait_n(8);
        chk("release_btn",   button_export, 4'hF);
        chk("release_flags", press_flags,   EDGE_EN ? 4'h4 : 4'h0);
        flags_clear = 4'hF;
        wait_n(1);
        flags_clear = 4'h0;
        chk("clear_all", press_flags, 4'h0);

        // bounce on button 0: low 3, high 1, low 3, high
        key_n_in[0] = 1'b0;
        wait_n(3);
        key_n_in[0] = 1'b1;
        wait_n(1);
        key_n_in[0] = 1'b0;
        wait_n(3);
        key_n_in[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_n(1);
            chk("bounce_btn0",  button_export[0], 1'b1);
            chk("bounce_pulse", press_pulse,      4'h0);
            chk("bounce_flags", press_flags,      4'h0);
        end

        // flag clear race on button 1
        key_n_in[1] = 1'b0;
        wait_n(6);
        chk("race_set", press_flags, EDGE_EN ? 4'h2 : 4'h0);
        key_n_in[1] = 1'b1;
        wait_n(8);
        flags_clear = 4'h2;
        wait_n(1);
        flags_clear = 4'h0;
        chk("race_clear", press_flags, 4'h0);
        key_n_in[1] = 1'b0;
        wait_n(5);
        flags_clear = 4'h2;
        wait_n(1);
        chk("race_pulse",   press_pulse, EDGE_EN ? 4'h2 : 4'h0);
        chk("race_setwins", press_flags, EDGE_EN ? 4'h2 : 4'h0);
        flags_clear = 4'h0;
        wait_n(1);
        chk("race_hold", press_flags, EDGE_EN ? 4'h2 : 4'h0);
        key_n_in[1] = 1'b1;
        wait_n(8);

        // all 14 inputs change together
        key_n_in = 4'h0;
        sw_in    = 10'h000;
        wait_n(5);
        chk("simul_btn_5", button_export, 4'hF);
        chk("simul_sw_5",  switch_export, 10'h3FF);
        wait_n(1);
        chk("simul_btn_6",   button_export, 4'h0);
        chk("simul_sw_6",    switch_export, 10'h000);
        chk("simul_pulse_6", press_pulse,   EDGE_EN ? 4'hF : 4'h0);
        wait_n(1);
        chk("simul_pulse_7", press_pulse, 4'h0);
        key_n_in = 4'hF;
        sw_in    = 10'($urandom_range(0, 1023));
        wait_n(8);

        // reset in the middle of a count on button 3
        key_n_in[3] = 1'b0;
        wait_n(5);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_btn",   button_export, 4'hF);
        chk("midrst_sw",    switch_export, 10'h000);
        chk("midrst_pulse", press_pulse,   4'h0);
        chk("midrst_flags", press_flags,   4'h0);
        wait_n(2);
        #2 rst_n = 1'b1;
        n_pulse = 0;
        for (int k = 1; k <= 12; k++) begin
            wait_n(1);
            if (press_pulse[3]) n_pulse++;
            if (k == 5) chk("midrst_btn_5", button_export, 4'hF);
            if (k == 6) chk("midrst_btn_6", button_export, 4'h7);
        end
        chk("midrst_one_pulse", n_pulse, EDGE_EN ? 1 : 0);
        key_n_in[3] = 1'b1;
        wait_n(8);

        // random phase, scoreboard does the checking
        for (int it = 0; it < 300; it++) begin
            key_n_in = key_n_in ^ 4'($urandom_range(0, 15));
            sw_in    = sw_in ^ 10'($urandom_range(0, 1023) & $urandom_range(0, 1023));
            hold     = $urandom_range(1, 2 * D + 2);
            if (it == 150) begin
                #2 rst_n = 1'b0;
                wait_n(2);
                #2 rst_n = 1'b1;
            end
            repeat (hold) begin
                flags_clear = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                wait_n(1);
            end
        end
        flags_clear = 4'h0;
        wait_n(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/board_input_debouncer.md
# board_input_debouncer

- Conditions the raw DE-board pushbuttons and slide switches before they reach the Nios system's button and switch PIO exports.
- Per-bit processing: two-flop synchronizer, then a counter-based debouncer; the stable levels go to the PIOs.
- Optionally derives per-button press pulses and sticky press flags for the top level.
- Sits between the FPGA input pins and the Qsys system instance; it is the input-side counterpart of the system's HEX/LED output exports.

## Interface

- N_BUTTONS, 4: number of pushbuttons.
- N_SWITCHES, 10: number of slide switches.
- DEBOUNCE_CYCLES, 500000: clocks an input must stay stable before it is accepted (10 ms at 50 MHz); minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES): debounce counter width.

- clk_clk  in  1  system clock, shared with the Nios system.
- reset_reset_n  in  1  asynchronous, active-low reset.
- key_n_in  in  N_BUTTONS  raw pushbuttons, active-low (0 = pressed), asynchronous to clk_clk.
- sw_in  in  N_SWITCHES  raw slide switches, asynchronous to clk_clk.
- button_export  out  N_BUTTONS  debounced button levels, active-low preserved; drives button_external_connection_export.
- switch_export  out  N_SWITCHES  debounced switch levels; drives switch_external_connection_export.
- press_pulse  out  N_BUTTONS  one-cycle pulse per accepted press (edge-capture build only).
- press_flags  out  N_BUTTONS  sticky press flags (edge-capture build only).
- flags_clear  in  N_BUTTONS  per-bit clear mask for press_flags (edge-capture build only).

## Operation

- Every input bit gets an identical, independent channel: sync1 -> sync2 -> debouncer (stable register plus counter cnt).
- Debouncer rules, applied each clock:
  - sync2 == stable: cnt <= 0.
  - sync2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- Any glitch back to the stable value restarts the count from zero.
- Outputs come directly from the stable registers; there is no combinational path from the pins.
- Press detection: debounced button falling edge, i.e. stable goes 1 -> 0.
  - press_pulse bit is high for exactly the one cycle after stable falls.
  - press_flags bit sets on the same cycle and holds until cleared.
- flags_clear[i] high clears press_flags[i] on the next edge.
- Set and clear in the same cycle: set wins, and the flag stays 1.
- Release (stable 0 -> 1) produces no pulse and leaves the flag unchanged.

## Timing

- Reset values (asynchronous): button sync regs and stable = all 1 (released); switch sync regs and stable = 0; all cnt = 0; press_pulse = 0; press_flags = 0.
- The button reset value of 1 ensures that a button held through reset produces exactly one press after release-free deassertion, never a spurious one at reset.
- Latency: for a pin change held steady, the export changes DEBOUNCE_CYCLES+2 clocks after the change is first sampled: 2 cycles of synchronizer, then DEBOUNCE_CYCLES of counting.
- press_pulse is asserted in the same cycle that button_export[i] first reads 0.
- A pulse shorter than DEBOUNCE_CYCLES at sync2 is fully rejected, and the output is unchanged.
- Reset asserted mid-count: the counter is abandoned, and outputs and flags return to reset values immediately.
- cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.

## Configuration

- BUTTON_EDGE_CAPTURE_EN defined: press_pulse, press_flags and flags_clear logic is present as described above.
- Undefined: the ports remain, press_pulse and press_flags are tied to 0, flags_clear is ignored, and no edge or flag registers are built.
- Debouncing of both exports is unaffected by the macro.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4 with BUTTON_EDGE_CAPTURE_EN defined.

- Reset: release reset with key_n_in=4'hF and sw_in=10'h3FF.
  - Required: button_export=4'hF and switch_export=0 immediately.
  - Required: switch_export=10'h3FF exactly 6 clocks later.
  - Required: press_flags=0 throughout.
- Clean press: drive key_n_in[2] low and hold.
  - Required: button_export[2]=0 and press_pulse=4'b0100 for exactly 1 cycle, 6 clocks after the first sample.
  - Required: press_flags=4'b0100 from then on.
- Bounce rejection: key_n_in[0] toggles low for 3 cycles, high for 1, low for 3, then high.
  - Required: button_export[0] stays 1, press_pulse stays 0, press_flags stays 0.
- Flag clear race: with press_flags[1]=1, pulse flags_clear=4'b0010 for 1 cycle, giving flag 0 next cycle.
  - Then make a second press's pulse coincide with flags_clear[1]=1.
  - Required: press_flags[1]=1.
- Simultaneous inputs: change all 4 buttons and all 10 switches on the same edge.
  - Required: all 14 exports update on the same cycle, 6 clocks later.
  - Required: press_pulse=4'hF for 1 cycle.
- Reset mid-count: start a press on key_n_in[3] and assert reset_reset_n=0 after 3 counted cycles.
  - Required: outputs return to reset values asynchronously.
  - Required: after reset release with the key still held, the press is accepted 6 clocks later, with exactly one pulse.
